// File: rtl/page_nav_pkg.sv
// Shared page codes, key indices and menu-to-page mapping for the page navigation controller.
package page_nav_pkg;

   typedef logic [1:0] page_t;

   localparam page_t PAGE_MAIN = 2'd0;
   localparam page_t PAGE_HELP = 2'd1;
   localparam page_t PAGE_TEST = 2'd2;
   localparam page_t PAGE_GAME = 2'd3;

   localparam int NUM_KEYS  = 5;
   localparam int KEY_UP    = 0;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 2;
   localparam int KEY_DOWN  = 3;
   localparam int KEY_SPACE = 4;

   localparam page_t MENU0_PAGE = PAGE_GAME;
   localparam page_t MENU1_PAGE = PAGE_HELP;
   localparam page_t MENU2_PAGE = PAGE_TEST;
   localparam page_t MENU3_PAGE = PAGE_MAIN;

   function automatic page_t menu_to_page(input logic [1:0] sel);
      page_t pg;
      case (sel)
         2'd0:    pg = MENU0_PAGE;
         2'd1:    pg = MENU1_PAGE;
         2'd2:    pg = MENU2_PAGE;
         default: pg = MENU3_PAGE;
      endcase
      return pg;
   endfunction

endpackage

// File: rtl/page_nav_ctrl_key_edge_sync.sv
// Key synchroniser, sample-tick edge detector and priority encoder producing one-hot accepted events.
// Optional auto-repeat of left/right is built when PAGE_NAV_KEY_REPEAT_EN is defined.
module key_edge_sync
   import page_nav_pkg::*;
#(
   parameter int SAMPLE_DIV   = 64,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                repeat_allow,
   output logic [NUM_KEYS-1:0] accept
);

   localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [NUM_KEYS-1:0] prev_q, prev_d;
   logic [NUM_KEYS-1:0] accept_q, accept_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_KEYS-1:0] key_rise, rpt_fire, cand;
   logic                tick;

   assign tick     = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
   assign key_rise = ~prev_q & sync2_q;

`ifdef PAGE_NAV_KEY_REPEAT_EN
   localparam int RPT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY + 1) : 1;

   logic             rpt_active_q, rpt_active_d;
   logic             rpt_key_q, rpt_key_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_held;

   assign rpt_held = rpt_key_q ? sync2_q[KEY_RIGHT] : sync2_q[KEY_LEFT];

   // A fresh left/right press restarts tracking; the press itself is the real edge event
   always_comb begin
      rpt_active_d = rpt_active_q;
      rpt_key_d    = rpt_key_q;
      rpt_cnt_d    = rpt_cnt_q;
      rpt_fire     = '0;
      if (tick) begin
         if (!repeat_allow) begin
            rpt_active_d = 1'b0;
            rpt_cnt_d    = '0;
         end else if (key_rise[KEY_LEFT] || key_rise[KEY_RIGHT]) begin
            rpt_active_d = 1'b1;
            rpt_key_d    = ~key_rise[KEY_LEFT];
            rpt_cnt_d    = '0;
         end else if (rpt_active_q && rpt_held) begin
            if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
               rpt_fire[rpt_key_q ? KEY_RIGHT : KEY_LEFT] = 1'b1;
               rpt_cnt_d = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end else begin
            rpt_active_d = 1'b0;
            rpt_cnt_d    = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rpt_active_q <= 1'b0;
         rpt_key_q    <= 1'b0;
         rpt_cnt_q    <= '0;
      end else begin
         rpt_active_q <= rpt_active_d;
         rpt_key_q    <= rpt_key_d;
         rpt_cnt_q    <= rpt_cnt_d;
      end
   end
`else
   logic unused_rpt;
   assign unused_rpt = ^{repeat_allow, REPEAT_DELAY[0], REPEAT_RATE[0]};
   assign rpt_fire   = '0;
`endif

   assign cand = key_rise | rpt_fire;

   // Lowest set bit wins, which is exactly the up > left > right > down > space order
   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + 1'b1;
      prev_d   = tick ? sync2_q : prev_q;
      accept_d = tick ? (cand & (~cand + 5'd1)) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         prev_q   <= '1;
         cnt_q    <= '0;
         accept_q <= '0;
      end else begin
         sync1_q  <= keys;
         sync2_q  <= sync1_q;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
      end
   end

   assign accept = accept_q;

endmodule

// File: rtl/page_nav_ctrl.sv
// Page navigation controller: turns accepted key events into menu moves and frame-aligned page commits.
// Define PAGE_NAV_KEY_REPEAT_EN to enable left/right auto-repeat on the main menu.
module page_nav_ctrl
   import page_nav_pkg::*;
#(
   parameter int SAMPLE_DIV   = 64,
   parameter int MENU_ITEMS   = 3,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   input  logic                frame_start,
   output logic [1:0]          page_status,
   output logic [1:0]          menu_sel,
   output logic [NUM_KEYS-1:0] key_event,
   output logic                pending,
   output logic                page_changed
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;
   localparam logic [1:0] MAX_SEL = 2'(MENU_ITEMS - 1);

   logic [0:0]          state_q, state_d;
   page_t               page_q, page_d;
   page_t               target_q, target_d;
   logic [1:0]          menu_q, menu_d;
   logic                changed_q, changed_d;
   logic [NUM_KEYS-1:0] ev;
   logic                req;
   page_t               req_page;

   key_edge_sync #(
      .SAMPLE_DIV   (SAMPLE_DIV),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_keys (
      .clk          (clk),
      .rst          (rst),
      .keys         (keys),
      .repeat_allow ((page_q == PAGE_MAIN) && (state_q == ST_IDLE)),
      .accept       (ev)
   );

   // While pending, only the frame boundary matters; events are dropped
   always_comb begin
      state_d   = state_q;
      page_d    = page_q;
      target_d  = target_q;
      menu_d    = menu_q;
      changed_d = 1'b0;
      req       = 1'b0;
      req_page  = page_q;
      if (state_q == ST_PEND) begin
         if (frame_start) begin
            page_d    = target_q;
            state_d   = ST_IDLE;
            changed_d = 1'b1;
         end
      end else if (|ev) begin
         case (page_q)
            PAGE_MAIN: begin
               if (ev[KEY_UP]) begin
                  req      = 1'b1;
                  req_page = PAGE_TEST;
               end else if (ev[KEY_DOWN]) begin
                  req      = 1'b1;
                  req_page = PAGE_HELP;
               end else if (ev[KEY_LEFT]) begin
                  menu_d = (menu_q == 2'd0) ? MAX_SEL : menu_q - 2'd1;
               end else if (ev[KEY_RIGHT]) begin
                  menu_d = (menu_q >= MAX_SEL) ? 2'd0 : menu_q + 2'd1;
               end else if (ev[KEY_SPACE]) begin
                  req      = 1'b1;
                  req_page = menu_to_page(menu_q);
               end
            end
            PAGE_HELP: begin
               if (ev[KEY_DOWN] || ev[KEY_SPACE]) begin
                  req      = 1'b1;
                  req_page = PAGE_MAIN;
               end
            end
            default: begin
               if (ev[KEY_DOWN]) begin
                  req      = 1'b1;
                  req_page = PAGE_MAIN;
               end
            end
         endcase
         if (req && (req_page != page_q)) begin
            target_d = req_page;
            state_d  = ST_PEND;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         page_q    <= PAGE_MAIN;
         target_q  <= PAGE_MAIN;
         menu_q    <= 2'd0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         page_q    <= page_d;
         target_q  <= target_d;
         menu_q    <= menu_d;
         changed_q <= changed_d;
      end
   end

   assign page_status  = page_q;
   assign menu_sel     = menu_q;
   assign key_event    = ev;
   assign pending      = (state_q == ST_PEND);
   assign page_changed = changed_q;

endmodule

// File: tb/tb_page_nav_ctrl.sv
// Scoreboard bench for page_nav_ctrl: directed key presses push expected events and page commits,
// an independent monitor pops and compares them whenever key_event or page_changed fires.
module tb_page_nav_ctrl;

   localparam int SAMPLE_DIV   = 4;
   localparam int MENU_ITEMS   = 3;
   localparam int REPEAT_DELAY = 3;
   localparam int REPEAT_RATE  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] keys = 5'b0;
   logic       frame_start = 1'b0;
   logic [1:0] page_status;
   logic [1:0] menu_sel;
   logic [4:0] key_event;
   logic       pending;
   logic       page_changed;

   int checks = 0;
   int errors = 0;

   logic [4:0] expKeyQ[$];
   logic [1:0] expMenuQ[$];
   logic [1:0] expPageQ[$];

   page_nav_ctrl #(
      .SAMPLE_DIV   (SAMPLE_DIV),
      .MENU_ITEMS   (MENU_ITEMS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .keys         (keys),
      .frame_start  (frame_start),
      .page_status  (page_status),
      .menu_sel     (menu_sel),
      .key_event    (key_event),
      .pending      (pending),
      .page_changed (page_changed)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expectEvent(input logic [4:0] k, input logic [1:0] menuAfter);
      expKeyQ.push_back(k);
      expMenuQ.push_back(menuAfter);
   endtask

   task automatic applyStimulus(input logic [4:0] k, input int holdCycles);
      keys = k;
      cycles(holdCycles);
      keys = 5'b0;
      cycles(10);
   endtask

   task automatic pulseFrame();
      frame_start = 1'b1;
      cycles(1);
      frame_start = 1'b0;
      cycles(2);
   endtask

   // Monitor: menu_sel is checked one cycle after its key_event, page_changed must be a single cycle
   initial begin : monitor
      logic       menuDue;
      logic [1:0] menuExp;
      logic       changedSeen;
      logic [4:0] ek;
      logic [1:0] ep;
      menuDue     = 1'b0;
      menuExp     = 2'd0;
      changedSeen = 1'b0;
      forever begin
         @(negedge clk);
         if (menuDue) begin
            checkOutput("menu_sel", menu_sel, menuExp);
            menuDue = 1'b0;
         end
         if (changedSeen) begin
            checkOutput("page_changed width", page_changed, 0);
            changedSeen = 1'b0;
         end
         if (key_event != 5'b0) begin
            if (expKeyQ.size() == 0) begin
               checkOutput("unexpected key_event", key_event, 0);
            end else begin
               ek      = expKeyQ.pop_front();
               menuExp = expMenuQ.pop_front();
               checkOutput("key_event", key_event, ek);
               menuDue = 1'b1;
            end
         end
         if (page_changed) begin
            changedSeen = 1'b1;
            if (expPageQ.size() == 0) begin
               checkOutput("unexpected page_changed", page_changed, 0);
            end else begin
               ep = expPageQ.pop_front();
               checkOutput("committed page", page_status, ep);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not end, expected it to finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      $display("[TB] start");
      cycles(3);
      checkOutput("reset page_status", page_status, 0);
      checkOutput("reset menu_sel", menu_sel, 0);
      checkOutput("reset key_event", key_event, 0);
      checkOutput("reset pending", pending, 0);
      checkOutput("reset page_changed", page_changed, 0);
      rst = 1'b1;
      cycles(2);

      // down in MAIN requests HELP, committed only on frame_start
      expectEvent(5'b01000, 2'd0);
      applyStimulus(5'b01000, 8);
      checkOutput("pending after down", pending, 1);
      checkOutput("page before frame", page_status, 0);
      cycles(5);
      checkOutput("page still before frame", page_status, 0);
      expPageQ.push_back(2'd1);
      pulseFrame();
      checkOutput("page HELP", page_status, 1);
      checkOutput("pending cleared", pending, 0);

      // HELP: space twice while pending gives one request and one commit
      expectEvent(5'b10000, 2'd0);
      applyStimulus(5'b10000, 8);
      checkOutput("pending HELP space", pending, 1);
      expectEvent(5'b10000, 2'd0);
      applyStimulus(5'b10000, 8);
      checkOutput("pending still set", pending, 1);
      checkOutput("page still HELP", page_status, 1);
      expPageQ.push_back(2'd0);
      pulseFrame();
      checkOutput("page back MAIN", page_status, 0);
      pulseFrame();
      checkOutput("idle frame no change", page_status, 0);

      // menu cursor wrap both ways, then space on item 2 selects TEST
      expectEvent(5'b00100, 2'd1);
      applyStimulus(5'b00100, 8);
      expectEvent(5'b00100, 2'd2);
      applyStimulus(5'b00100, 8);
      expectEvent(5'b00100, 2'd0);
      applyStimulus(5'b00100, 8);
      expectEvent(5'b00010, 2'd2);
      applyStimulus(5'b00010, 8);
      checkOutput("menu after left wrap", menu_sel, 2);
      checkOutput("menu move no pending", pending, 0);
      expectEvent(5'b10000, 2'd2);
      applyStimulus(5'b10000, 8);
      checkOutput("pending space TEST", pending, 1);
      expPageQ.push_back(2'd2);
      pulseFrame();
      checkOutput("page TEST", page_status, 2);

      // up in TEST is a no-op that still pulses; down returns to MAIN
      expectEvent(5'b00001, 2'd2);
      applyStimulus(5'b00001, 8);
      checkOutput("TEST up no request", pending, 0);
      expectEvent(5'b01000, 2'd2);
      applyStimulus(5'b01000, 8);
      expPageQ.push_back(2'd0);
      pulseFrame();
      checkOutput("page MAIN again", page_status, 0);

      // up and down on the same tick: up wins, down is lost
      expectEvent(5'b00001, 2'd2);
      applyStimulus(5'b01001, 8);
      checkOutput("pending up priority", pending, 1);
      expPageQ.push_back(2'd2);
      pulseFrame();
      checkOutput("page TEST by up", page_status, 2);
      expectEvent(5'b01000, 2'd2);
      applyStimulus(5'b01000, 8);
      expPageQ.push_back(2'd0);
      pulseFrame();

      // key held through reset must be released before it counts
      keys = 5'b01000;
      rst  = 1'b0;
      cycles(2);
      checkOutput("menu_sel reset", menu_sel, 0);
      rst = 1'b1;
      cycles(16);
      checkOutput("held key ignored", pending, 0);
      keys = 5'b0;
      cycles(10);
      expectEvent(5'b01000, 2'd0);
      applyStimulus(5'b01000, 8);
      expPageQ.push_back(2'd1);
      pulseFrame();
      checkOutput("page HELP after reset", page_status, 1);
      expectEvent(5'b01000, 2'd0);
      applyStimulus(5'b01000, 8);
      checkOutput("pending before reset", pending, 1);
      rst = 1'b0;
      #1;
      checkOutput("async reset page", page_status, 0);
      checkOutput("async reset pending", pending, 0);
      cycles(2);
      rst = 1'b1;
      cycles(4);

      // right held for 20 ticks in MAIN
`ifdef PAGE_NAV_KEY_REPEAT_EN
      for (int i = 0; i < 10; i++) begin
         expectEvent(5'b00100, 2'((i + 1) % MENU_ITEMS));
      end
`else
      expectEvent(5'b00100, 2'd1);
`endif
      applyStimulus(5'b00100, 20 * SAMPLE_DIV);

      cycles(5);
      checkOutput("key_event queue drained", expKeyQ.size(), 0);
      checkOutput("page queue drained", expPageQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
